// File: rtl/adc_capture_sequencer_pkg.sv
// Shared types and bit positions for the ADC capture sequencer:
// FSM state encoding, PS GPIO bus layout and CTRL register bit map.
package adc_capture_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DELAY    = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam int GPIO_ADDR_LSB = 0;
    localparam int GPIO_ADDR_W   = 16;
    localparam int GPIO_DATA_LSB = 16;
    localparam int GPIO_DATA_W   = 8;
    localparam int GPIO_WCLK_BIT = 24;

    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_SW_TRIG = 1;
    localparam int CTRL_ABORT   = 2;
    localparam int CTRL_CLEAR   = 3;

    // A programmed length of zero means a full 1024-word capture.
    function automatic logic [10:0] len_words(input logic [9:0] len);
        return (len == 10'd0) ? 11'd1024 : {1'b0, len};
    endfunction

endpackage

// File: rtl/adc_capture_sequencer_if.sv
// Capture-side signals between the sequencer (master) and the experiment
// FSM / readback FIFO / peak detector (slave).
interface adc_capture_sequencer_if;
    import adc_capture_sequencer_pkg::*;

    // buffer_valid is a write enable, not a stalled handshake: each cycle it is
    // high one ADC word is offered; if fifo_ready is low that word is lost and
    // the sticky overflow flag records it. buffer_valid never waits on ready.
    logic       fsm_trig;
    logic       fifo_ready;
    logic       buffer_valid;
    logic       scaler_run;
    logic       busy;
    logic       done;
    logic [3:0] status;
    state_t     dbg_state;

    modport master (
        input  fsm_trig, fifo_ready,
        output buffer_valid, scaler_run, busy, done, status, dbg_state
    );

    modport slave (
        output fsm_trig, fifo_ready,
        input  buffer_valid, scaler_run, busy, done, status, dbg_state
    );

endinterface

// File: rtl/gpio_reg_decoder.sv
// Turns the PS GPIO bus into register write strobes: w_clk is synchronised
// through two flops and each rising edge writes the addressed register.
module gpio_reg_decoder
    import adc_capture_sequencer_pkg::*;
#(
    parameter logic [15:0] DLY_REG_ADDR    = 16'h0010,
    parameter logic [15:0] LEN_LO_REG_ADDR = 16'h0011,
    parameter logic [15:0] LEN_HI_REG_ADDR = 16'h0012,
    parameter logic [15:0] CTRL_REG_ADDR   = 16'h0013
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_gpio,
    output logic        o_wr_dly,
    output logic        o_wr_len_lo,
    output logic        o_wr_len_hi,
    output logic        o_wr_ctrl,
    output logic [7:0]  o_wdata
);

    logic [1:0]  r_sync;
    logic        r_wclk_d;
    logic        w_rise;
    logic [15:0] w_addr;
    logic        w_unused;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_sync   <= 2'b00;
            r_wclk_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_gpio[GPIO_WCLK_BIT]};
            r_wclk_d <= r_sync[1];
        end
    end

    // Address and data are held stable by software across the w_clk pulse.
    assign w_rise      = r_sync[1] & ~r_wclk_d;
    assign w_addr      = i_gpio[GPIO_ADDR_LSB +: GPIO_ADDR_W];
    assign o_wdata     = i_gpio[GPIO_DATA_LSB +: GPIO_DATA_W];
    assign o_wr_dly    = w_rise && (w_addr == DLY_REG_ADDR);
    assign o_wr_len_lo = w_rise && (w_addr == LEN_LO_REG_ADDR);
    assign o_wr_len_hi = w_rise && (w_addr == LEN_HI_REG_ADDR);
    assign o_wr_ctrl   = w_rise && (w_addr == CTRL_REG_ADDR);
    assign w_unused    = ^i_gpio[31:25];

endmodule

// File: rtl/adc_capture_sequencer.sv
// ADC capture sequencer: waits for an FSM or software trigger, counts out a
// programmable delay, then enables the ADC FIFO write for a fixed word count.
module adc_capture_sequencer
    import adc_capture_sequencer_pkg::*;
#(
    parameter logic [15:0] DLY_REG_ADDR    = 16'h0010,
    parameter logic [15:0] LEN_LO_REG_ADDR = 16'h0011,
    parameter logic [15:0] LEN_HI_REG_ADDR = 16'h0012,
    parameter logic [15:0] CTRL_REG_ADDR   = 16'h0013
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             gpio_in,
    adc_capture_sequencer_if.master cap
);

    logic       w_wr_dly, w_wr_len_lo, w_wr_len_hi, w_wr_ctrl;
    logic [7:0] w_wdata;
    logic       w_sw_trig, w_abort, w_clear, w_enable_now;
    logic       w_fsm_go, w_sw_go, w_accept, w_missed_set, w_bv;

    state_t      r_state;
    logic [10:0] r_cnt;
    logic [7:0]  r_dly;
    logic [9:0]  r_len;
    logic [9:0]  r_len_lat;
    logic        r_enable, r_src_fsm, r_missed, r_overflow, r_done;

    gpio_reg_decoder #(
        .DLY_REG_ADDR    (DLY_REG_ADDR),
        .LEN_LO_REG_ADDR (LEN_LO_REG_ADDR),
        .LEN_HI_REG_ADDR (LEN_HI_REG_ADDR),
        .CTRL_REG_ADDR   (CTRL_REG_ADDR)
    ) u_decoder (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_gpio      (gpio_in),
        .o_wr_dly    (w_wr_dly),
        .o_wr_len_lo (w_wr_len_lo),
        .o_wr_len_hi (w_wr_len_hi),
        .o_wr_ctrl   (w_wr_ctrl),
        .o_wdata     (w_wdata)
    );

    assign w_sw_trig    = w_wr_ctrl && w_wdata[CTRL_SW_TRIG];
    assign w_abort      = w_wr_ctrl && w_wdata[CTRL_ABORT];
    assign w_clear      = w_wr_ctrl && w_wdata[CTRL_CLEAR];
    // A CTRL write carrying both enable and sw_trig arms and fires at once.
    assign w_enable_now = w_wr_ctrl ? w_wdata[CTRL_ENABLE] : r_enable;
    assign w_fsm_go     = (r_state == ST_IDLE) && w_enable_now && cap.fsm_trig;
    assign w_sw_go      = (r_state == ST_IDLE) && w_enable_now && w_sw_trig && !cap.fsm_trig;
    assign w_accept     = w_fsm_go || w_sw_go;
    assign w_missed_set = w_sw_trig && ((r_state != ST_IDLE) || !w_enable_now || cap.fsm_trig);
    assign w_bv         = (r_state == ST_CAPTURE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dly    <= 8'd0;
            r_len    <= 10'd0;
            r_enable <= 1'b0;
        end else begin
            if (w_wr_dly)    r_dly      <= w_wdata;
            if (w_wr_len_lo) r_len[7:0] <= w_wdata;
            if (w_wr_len_hi) r_len[9:8] <= w_wdata[1:0];
            if (w_wr_ctrl)   r_enable   <= w_wdata[CTRL_ENABLE];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 11'd0;
            r_len_lat <= 10'd0;
            r_src_fsm <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: if (w_accept) begin
                        r_src_fsm <= w_fsm_go;
                        r_len_lat <= r_len;
                        if (r_dly != 8'd0) begin
                            r_state <= ST_DELAY;
                            r_cnt   <= {3'b000, r_dly};
                        end else begin
                            r_state <= ST_CAPTURE;
                            r_cnt   <= len_words(r_len);
                        end
                    end
                    ST_DELAY: if (r_cnt == 11'd1) begin
                        r_state <= ST_CAPTURE;
                        r_cnt   <= len_words(r_len_lat);
                    end else begin
                        r_cnt <= r_cnt - 11'd1;
                    end
                    ST_CAPTURE: if (r_cnt == 11'd1) begin
                        r_done  <= 1'b1;
                        r_state <= r_src_fsm ? ST_WAIT_REL : ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 11'd1;
                    end
                    ST_WAIT_REL: if (!cap.fsm_trig) r_state <= ST_IDLE;
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Clear beats any same-cycle set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_missed   <= 1'b0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_missed   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_missed_set)              r_missed   <= 1'b1;
            if (w_bv && !cap.fifo_ready)   r_overflow <= 1'b1;
        end
    end

    assign cap.buffer_valid = w_bv;
    assign cap.scaler_run   = w_bv && r_src_fsm;
    assign cap.busy         = (r_state != ST_IDLE);
    assign cap.done         = r_done;
    assign cap.status       = {r_src_fsm, r_missed, r_overflow, r_enable};
    assign cap.dbg_state    = r_state;

endmodule

// File: doc/adc_capture_sequencer.md
ADC_CAPTURE_SEQUENCER -- requirements
Module: adc_capture_sequencer

Interface
REQ-001 SHALL have parameters (name, default, meaning): DLY_REG_ADDR, 16'h0010, trigger-delay register address.
REQ-002 SHALL have parameter LEN_LO_REG_ADDR, 16'h0011, capture length bits 7:0.
REQ-003 SHALL have parameter LEN_HI_REG_ADDR, 16'h0012, capture length bits 9:8 in data[1:0].
REQ-004 SHALL have parameter CTRL_REG_ADDR, 16'h0013, control register.
REQ-005 SHALL have port clk  in  1  system clock.
REQ-006 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port gpio_in  in  32  PS GPIO bus: [15:0] addr, [23:16] data, [24] w_clk.
REQ-008 SHALL have port fsm_trig  in  1  experiment FSM capture request, level.
REQ-009 SHALL have port fifo_ready  in  1  ADC readback FIFO write-side ready.
REQ-010 SHALL have port buffer_valid  out  1  FIFO write enable for ADC words.
REQ-011 SHALL have port scaler_run  out  1  peak-detector run enable.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port done  out  1  one-cycle pulse on capture completion.
REQ-014 SHALL have port status  out  4  {src_is_fsm, missed, overflow, enable}.

Function
REQ-015 SHALL synchronise w_clk through two flops and perform a register write on its detected rising edge when addr matches.
REQ-016 SHALL implement CTRL data bits: [0] enable (stored), [1] sw_trig (one-cycle pulse, not stored), [2] abort (pulse), [3] clear sticky flags (pulse).
REQ-017 SHALL latch delay (8b) and length (10b) at capture start; writes during a capture affect only the next capture.
REQ-018 SHALL treat length 0 as 1024 words.
REQ-019 SHALL implement states IDLE, DELAY, CAPTURE, WAIT_REL.
REQ-020 SHALL, in IDLE with enable=1, accept fsm_trig=1 (source FSM) or sw_trig (source SW); FSM has priority on a same-cycle conflict.
REQ-021 SHALL move IDLE->DELAY when delay>0, else IDLE->CAPTURE, in the cycle after acceptance.
REQ-022 SHALL stay in DELAY exactly delay cycles, then go to CAPTURE.
REQ-023 SHALL assert buffer_valid for exactly length consecutive CAPTURE cycles.
REQ-024 SHALL assert scaler_run coincident with buffer_valid only when source is FSM.
REQ-025 SHALL pulse done in the cycle after the last buffer_valid cycle and enter WAIT_REL (source FSM) or IDLE (source SW).
REQ-026 SHALL leave WAIT_REL for IDLE when fsm_trig=0, so one FSM level yields one capture.
REQ-027 SHALL set sticky overflow when buffer_valid=1 and fifo_ready=0; capture continues unchanged.
REQ-028 SHALL set sticky missed when sw_trig arrives while busy, arrives while enable=0, or loses arbitration.
REQ-029 SHALL, on abort, return to IDLE the next cycle from any state, drop buffer_valid/scaler_run, and not pulse done.
REQ-030 SHALL give clear priority over same-cycle set for sticky flags.
REQ-031 SHALL, on enable=0 mid-capture, finish the current capture normally.

Reset
REQ-032 SHALL on rst=0 set state IDLE, all outputs 0, enable 0, delay 0, length 0, flags 0, synchroniser flops 0.
REQ-033 SHALL on reset mid-capture drop buffer_valid immediately, without done.

Structure
REQ-034 SHALL place the state enum, GPIO bit positions (addr/data/w_clk) and CTRL bit indices in the shared package.
REQ-035 SHALL use one sub-module, gpio_reg_decoder (synchroniser, edge detect, address match, write strobes).

Verification
REQ-036 SHALL test: enable=1, delay=5, length=8, fsm_trig high -> buffer_valid and scaler_run high exactly 8 cycles beginning 6 cycles after acceptance, done once, no second capture until fsm_trig falls.
REQ-037 SHALL test: length=0, delay=0, sw_trig -> buffer_valid 1024 cycles, scaler_run stays 0, done pulse, IDLE.
REQ-038 SHALL test: fsm_trig and sw_trig same cycle -> source FSM, missed=1; clear bit -> missed=0.
REQ-039 SHALL test: fifo_ready=0 for 3 cycles mid-capture -> overflow=1, buffer_valid count unchanged.
REQ-040 SHALL test: abort in cycle 4 of a 100-word capture -> buffer_valid low next cycle, no done, busy=0.
REQ-041 SHALL test: length rewritten to 20 during a 10-word capture -> current capture 10 words, next 20.
